// File: rtl/chu_sampler_fifo_core.sv
// chu_sampler_fifo_core: programmable-rate sampler filling a 2^D-entry FIFO.
// Define SAMPLER_TRIG_EN for the trig input, ARMED state and one-shot capture.
module chu_sampler_fifo_core #(
    parameter int W = 16,
    parameter int D = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    output logic [31:0]  rd_data,
    input  logic [31:0]  wr_data,
    input  logic [W-1:0] din
`ifdef SAMPLER_TRIG_EN
    ,
    input  logic         trig
`endif
);

    localparam int DEPTH = 1 << D;
    localparam logic [D:0] FULL_CNT = (D+1)'(DEPTH);

`ifdef SAMPLER_TRIG_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd2
    } state_t;
`endif

    state_t state, state_nxt;

    logic         en;
    logic [31:0]  div;
    logic [31:0]  cnt;
    logic         run;
    logic         tick;
    logic         stop_full;

    logic [W-1:0] mem [DEPTH];
    logic [D-1:0] wr_ptr, rd_ptr;
    logic [D:0]   count, count_nxt;
    logic         ovf;
    logic         full, empty;
    logic         do_push, do_pop, drop;
    logic [W-1:0] head;

    logic wr_en, wr_ctrl, wr_div, wr_pop, wr_clr;
    logic unused;

    assign wr_en   = cs && write;
    assign wr_ctrl = wr_en && (addr[2:0] == 3'd0);
    assign wr_div  = wr_en && (addr[2:0] == 3'd1);
    assign wr_pop  = wr_en && (addr[2:0] == 3'd2);
    assign wr_clr  = wr_en && (addr[2:0] == 3'd3);
    assign unused  = &{1'b0, read, addr[4:3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en  <= 1'b0;
            div <= '0;
        end else begin
            if (wr_ctrl) en <= wr_data[0];
            if (wr_div) div <= wr_data;
        end
    end

`ifdef SAMPLER_TRIG_EN
    logic arm;
    logic trig_q;
    logic trig_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm    <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            if (wr_ctrl) arm <= wr_data[1];
            trig_q <= trig;
        end
    end

    assign trig_rise = trig && !trig_q;
    // One-shot burst ends on the edge that fills the FIFO.
    assign stop_full = arm && (count_nxt == FULL_CNT);
`else
    assign stop_full = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (wr_ctrl && wr_data[0]) begin
`ifdef SAMPLER_TRIG_EN
                    state_nxt = wr_data[1] ? ARMED : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
`ifdef SAMPLER_TRIG_EN
            ARMED: begin
                if (trig_rise) state_nxt = RUN;
            end
`endif
            RUN: begin
                if (stop_full) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (wr_clr || (wr_ctrl && !wr_data[0])) state_nxt = IDLE;
    end

    always_comb begin
        run  = (state == RUN);
        tick = run && (cnt == div);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!run || state_nxt != RUN || tick)
            cnt <= '0;
        else
            cnt <= cnt + 32'd1;
    end

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = wr_pop && !empty;
    // A pop frees the slot, so a tick on a full FIFO is kept.
    assign do_push = tick && (!full || do_pop);
    assign drop    = tick && full && !do_pop;

    always_comb begin
        count_nxt = count;
        if (wr_clr)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (wr_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr];

    always_comb begin
        rd_data = '0;
        case (addr[2:0])
            3'd0:    rd_data = {13'b0, ovf, full, empty, 16'(head)};
            3'd1:    rd_data = {5'b0, state, en, 24'(count)};
            default: rd_data = '0;
        endcase
    end

endmodule
